// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register stage carrying NCH register-write
// channels plus a HI/LO write. Each edge, in priority order, the stage is
// reset, flushed, bubbled (this stage stalled, the next stage free), held
// (this stage and the next stage stalled) or loaded from the inputs.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the bubble_cnt and
// hold_cnt saturating performance counters.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NCH     = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [NCH-1:0]        in_we,
    input  logic [NCH*ADDR_W-1:0] in_waddr,
    input  logic [NCH*DATA_W-1:0] in_wdata,
    input  logic                  in_whilo,
    input  logic [DATA_W-1:0]     in_hi,
    input  logic [DATA_W-1:0]     in_lo,
    output logic                  out_valid,
    output logic [NCH-1:0]        out_we,
    output logic [NCH*ADDR_W-1:0] out_waddr,
    output logic [NCH*DATA_W-1:0] out_wdata,
    output logic                  out_whilo,
    output logic [DATA_W-1:0]     out_hi,
    output logic [DATA_W-1:0]     out_lo
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           hold_cnt
`endif
);

    // A bad STAGE or channel count stops elaboration.
    generate
        if (STAGE < 0 || STAGE >= STALL_W || NCH < 1 || NCH > 4) begin : g_cfg_err
            $error("pipe_stage_reg: STAGE must be 0..STALL_W-1 and NCH must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_CAPTURE
    } action_e;

    logic    down_stall;
    action_e action;

    // The last stage has no downstream neighbour, so it can never hold.
    generate
        if (STAGE < STALL_W - 1) begin : g_down
            assign down_stall = stall[STAGE+1];
        end else begin : g_last
            assign down_stall = 1'b0;
        end
    endgenerate

    // Only two stall bits matter to this stage; the rest are folded here so
    // they read as intentionally ignored.
    logic unused_stall;
    assign unused_stall = ^stall;

    logic                  valid_q, valid_d;
    logic [NCH-1:0]        we_q, we_d;
    logic [NCH*ADDR_W-1:0] waddr_q, waddr_d;
    logic [NCH*DATA_W-1:0] wdata_q, wdata_d;
    logic                  whilo_q, whilo_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;

    // Pick this edge's action; reset is applied in the register itself.
    always_comb begin
        if (flush) begin
            action = ACT_FLUSH;
        end else if (stall[STAGE] && !down_stall) begin
            action = ACT_BUBBLE;
        end else if (stall[STAGE]) begin
            action = ACT_HOLD;
        end else begin
            action = ACT_CAPTURE;
        end
    end

    // Next stage contents. Write enables are dropped for an empty slot so a
    // bubble from upstream can never commit a write.
    always_comb begin
        // NOTE: every next-state signal gets a default first (here: keep the
        // current value) so no path through the case can infer a latch.
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (action)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d = 1'b0;
                we_d    = '0;
                waddr_d = '0;
                wdata_d = '0;
                whilo_d = 1'b0;
                hi_d    = '0;
                lo_d    = '0;
            end
            ACT_CAPTURE: begin
                valid_d = in_valid;
                we_d    = in_valid ? in_we : '0;
                waddr_d = in_waddr;
                wdata_d = in_wdata;
                whilo_d = in_valid & in_whilo;
                hi_d    = in_hi;
                lo_d    = in_lo;
            end
            default: ;  // ACT_HOLD keeps the defaults
        endcase
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the data fields are reset too, not just valid, because they
        // are visible outputs that must read zero after reset.
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            whilo_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign out_valid = valid_q;
    assign out_we    = we_q;
    assign out_waddr = waddr_q;
    assign out_wdata = wdata_q;
    assign out_whilo = whilo_q;
    assign out_hi    = hi_q;
    assign out_lo    = lo_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;

    // Saturating counts of bubble and hold edges; a flush counts as neither.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (action == ACT_BUBBLE && bubble_cnt_q != 32'hFFFF_FFFF) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (action == ACT_HOLD && hold_cnt_q != 32'hFFFF_FFFF) begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a STAGE=4 instance is the main DUT, and a
// STAGE=5 instance on the same inputs covers the last-stage case. Stimulus
// pushes the expected post-edge state into a queue; a monitor pops and
// compares one entry after each rising edge.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NC = 2;
    localparam int SW = 6;

    typedef struct packed {
        logic             valid;
        logic [NC-1:0]    we;
        logic [NC*AW-1:0] waddr;
        logic [NC*DW-1:0] wdata;
        logic             whilo;
        logic [DW-1:0]    hi;
        logic [DW-1:0]    lo;
    } vec_t;

    typedef struct {
        string       name;
        vec_t        main;
        logic [31:0] bub;
        logic [31:0] hold;
        bit          has_last;
        vec_t        last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [SW-1:0]    stall;
    logic             flush;
    logic             in_valid;
    logic [NC-1:0]    in_we;
    logic [NC*AW-1:0] in_waddr;
    logic [NC*DW-1:0] in_wdata;
    logic             in_whilo;
    logic [DW-1:0]    in_hi;
    logic [DW-1:0]    in_lo;

    logic             out_valid, l_valid;
    logic [NC-1:0]    out_we, l_we;
    logic [NC*AW-1:0] out_waddr, l_waddr;
    logic [NC*DW-1:0] out_wdata, l_wdata;
    logic             out_whilo, l_whilo;
    logic [DW-1:0]    out_hi, l_hi;
    logic [DW-1:0]    out_lo, l_lo;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]      bubble_cnt, hold_cnt;
    logic [31:0]      unused_l_bub, unused_l_hold;
`endif

    pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC), .STALL_W(SW), .STAGE(4)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .in_whilo(in_whilo), .in_hi(in_hi), .in_lo(in_lo),
        .out_valid(out_valid), .out_we(out_we), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .out_whilo(out_whilo), .out_hi(out_hi), .out_lo(out_lo)
`ifdef PIPE_STAGE_PERF_EN
        , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
    );

    pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .NCH(NC), .STALL_W(SW), .STAGE(5)) u_last (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .in_whilo(in_whilo), .in_hi(in_hi), .in_lo(in_lo),
        .out_valid(l_valid), .out_we(l_we), .out_waddr(l_waddr), .out_wdata(l_wdata),
        .out_whilo(l_whilo), .out_hi(l_hi), .out_lo(l_lo)
`ifdef PIPE_STAGE_PERF_EN
        , .bubble_cnt(unused_l_bub), .hold_cnt(unused_l_hold)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    exp_t e;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_vec(e.name, {out_valid, out_we, out_waddr, out_wdata, out_whilo, out_hi, out_lo}, e.main);
            if (e.has_last) begin
                check_vec({e.name, "_last"}, {l_valid, l_we, l_waddr, l_wdata, l_whilo, l_hi, l_lo}, e.last);
            end
`ifdef PIPE_STAGE_PERF_EN
            check_cnt({e.name, "_bubble_cnt"}, bubble_cnt, e.bub);
            check_cnt({e.name, "_hold_cnt"}, hold_cnt, e.hold);
`endif
        end
    end

    function automatic vec_t mk(input logic v, input logic [1:0] we,
                                input logic [4:0] a1, input logic [4:0] a0,
                                input logic [31:0] d1, input logic [31:0] d0,
                                input logic wh, input logic [31:0] hi, input logic [31:0] lo);
        vec_t r;
        r.valid = v;
        r.we    = we;
        r.waddr = {a1, a0};
        r.wdata = {d1, d0};
        r.whilo = wh;
        r.hi    = hi;
        r.lo    = lo;
        return r;
    endfunction

    // Drive one edge's inputs on the falling edge and queue what should follow.
    task automatic step(input string name, input vec_t v, input logic [SW-1:0] st,
                        input logic fl, input logic r, input vec_t em,
                        input int bub, input int hold, input bit hl, input vec_t el);
        exp_t x;
        @(negedge clk);
        rst      = r;
        flush    = fl;
        stall    = st;
        in_valid = v.valid;
        in_we    = v.we;
        in_waddr = v.waddr;
        in_wdata = v.wdata;
        in_whilo = v.whilo;
        in_hi    = v.hi;
        in_lo    = v.lo;
        x.name     = name;
        x.main     = em;
        x.bub      = bub;
        x.hold     = hold;
        x.has_last = hl;
        x.last     = el;
        sb_q.push_back(x);
    endtask

    localparam logic [SW-1:0] S0 = 6'b000000;
    localparam logic [SW-1:0] SB = 6'b010000;
    localparam logic [SW-1:0] SH = 6'b110000;
    localparam logic [SW-1:0] SL = 6'b100000;

    vec_t zero, va, vb, vc, vd, ve, vf, vg, vg_exp, vh;

    initial begin
        rst = 1'b0; flush = 1'b0; stall = '0; in_valid = 1'b0; in_we = '0;
        in_waddr = '0; in_wdata = '0; in_whilo = 1'b0; in_hi = '0; in_lo = '0;

        zero   = '0;
        va     = mk(1'b1, 2'b11,  3,  7, 32'h0000_000A, 32'h0000_000B, 1'b1, 32'h1111_0000, 32'h0000_2222);
        vb     = mk(1'b1, 2'b01, 12, 13, 32'hC0FF_EE00, 32'h0000_0055, 1'b0, 32'h0000_0001, 32'h0000_0002);
        vc     = mk(1'b1, 2'b10, 31,  1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hAAAA_5555, 32'h0F0F_0F0F);
        vd     = mk(1'b1, 2'b11,  4,  5, 32'h0000_0044, 32'h0000_0055, 1'b1, 32'h0000_0004, 32'h0000_0005);
        ve     = mk(1'b0, 2'b00,  6,  8, 32'h0000_0066, 32'h0000_0088, 1'b0, 32'h0000_0006, 32'h0000_0008);
        vf     = mk(1'b1, 2'b01,  9,  2, 32'h0000_0099, 32'h0000_0022, 1'b1, 32'h0000_0009, 32'h0000_0002);
        vg     = mk(1'b0, 2'b11, 10, 20, 32'hCAFE_F00D, 32'hBEEF_0001, 1'b1, 32'h0000_7777, 32'h0000_8888);
        vg_exp = mk(1'b0, 2'b00, 10, 20, 32'hCAFE_F00D, 32'hBEEF_0001, 1'b0, 32'h0000_7777, 32'h0000_8888);
        vh     = mk(1'b1, 2'b11, 17, 18, 32'h0000_1717, 32'h0000_1818, 1'b1, 32'h0000_0017, 32'h0000_0018);

        //   name            inputs stall flush rst  main    bub hold last? last
        step("reset",        va,    SH,   1'b1, 1'b1, zero,   0, 0, 1'b1, zero);
        step("capture",      va,    S0,   1'b0, 1'b0, va,     0, 0, 1'b1, va);
        step("bubble",       vb,    SB,   1'b0, 1'b0, zero,   1, 0, 1'b1, vb);
        step("capture2",     vc,    S0,   1'b0, 1'b0, vc,     1, 0, 1'b1, vc);
        step("hold1",        vd,    SH,   1'b0, 1'b0, vc,     1, 1, 1'b1, zero);
        step("hold2",        ve,    SH,   1'b0, 1'b0, vc,     1, 2, 1'b0, zero);
        step("hold3",        vf,    SH,   1'b0, 1'b0, vc,     1, 3, 1'b0, zero);
        step("release",      vf,    S0,   1'b0, 1'b0, vf,     1, 3, 1'b1, vf);
        step("hold4",        vh,    SH,   1'b0, 1'b0, vf,     1, 4, 1'b0, zero);
        step("flush_hold",   vh,    SH,   1'b1, 1'b0, zero,   1, 4, 1'b1, zero);
        step("invalid_gate", vg,    S0,   1'b0, 1'b0, vg_exp, 1, 4, 1'b1, vg_exp);
        step("capture3",     vh,    S0,   1'b0, 1'b0, vh,     1, 4, 1'b1, vh);
        step("hold5",        va,    SH,   1'b0, 1'b0, vh,     1, 5, 1'b0, zero);
        step("rst_hold",     va,    SH,   1'b1, 1'b1, zero,   0, 0, 1'b1, zero);
        step("post_rst",     vb,    S0,   1'b0, 1'b0, vb,     0, 0, 1'b1, vb);
        step("flush_cap",    vc,    S0,   1'b1, 1'b0, zero,   0, 0, 1'b1, zero);
        step("last_only",    vd,    SL,   1'b0, 1'b0, vd,     0, 0, 1'b1, zero);
        step("bubble2",      ve,    SB,   1'b0, 1'b0, zero,   1, 0, 1'b1, ve);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
